// File: rtl/lsu_ctrl_pkg.sv
// Shared RV32I load/store encodings, FSM state type and access decode helpers.
// Pure declarations; no timing. Imported by every lsu_ctrl file.
// No flow control of its own.
package lsu_ctrl_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } lsu_state_e;

    // Load context carried across the read-latency cycle.
    typedef struct packed {
        logic [2:0] funct3;
        logic [4:0] rd;
    } ld_pend_t;

    function automatic logic [2:0] access_size(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        if (we)
            return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW);
        else
            return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
                   (f3 == F3_LBU) || (f3 == F3_LHU);
    endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// Sign/zero extension of raw load data according to funct3.
// Combinational, zero latency.
// No backpressure.
module lsu_load_ext
    import lsu_ctrl_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [31:0] raw,
    output logic [31:0] ext
);

    always_comb begin
        ext = raw;
        case (funct3)
            F3_LB:   ext = {{24{raw[7]}}, raw[7:0]};
            F3_LH:   ext = {{16{raw[15]}}, raw[15:0]};
            F3_LBU:  ext = {24'b0, raw[7:0]};
            F3_LHU:  ext = {16'b0, raw[15:0]};
            default: ext = raw;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit: decodes and checks MEM-stage accesses and drives Data_mem.
// Stores take 1 cycle; loads write back 2 edges after issue; faults pulse 1 edge after.
// Stalls upstream (stall_o) for the single read-latency cycle of every load.
module lsu_ctrl
    import lsu_ctrl_pkg::*;
#(
    parameter int MEM_BYTES   = 256,
    parameter bit ALIGN_CHECK = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        stall_o,
    output logic        wb_valid_o,
    output logic [4:0]  wb_rd_o,
    output logic [31:0] wb_data_o,
    output logic        fault_o,
    output logic        fault_store_o,
    output logic [31:0] fault_addr_o,
    output logic [31:0] dm_addr,
    output logic        dm_mem_write,
    output logic        dm_mem_read,
    output logic        dm_half,
    output logic        dm_byte,
    output logic [31:0] dm_wdata,
    input  logic [31:0] dm_rdata
);

    lsu_state_e state, state_nxt;
    ld_pend_t   pend;
    logic [2:0] size;
    logic       in_range;
    logic       aligned;
    logic       legal;
    logic       accept;
    logic       bad;
    logic [31:0] ext_data;

    always_comb begin
        size     = access_size(req_funct3);
        // 33-bit sum so addresses near 2^32 cannot wrap into range.
        in_range = ({1'b0, req_addr} + {30'b0, size}) <= 33'(MEM_BYTES);
        case (size)
            3'd2:    aligned = ~req_addr[0];
            3'd4:    aligned = (req_addr[1:0] == 2'b00);
            default: aligned = 1'b1;
        endcase
        legal  = f3_legal(req_we, req_funct3) && in_range && (aligned || !ALIGN_CHECK);
        accept = (state == S_IDLE) && req_valid && legal;
        bad    = (state == S_IDLE) && req_valid && !legal;
    end

    assign dm_addr      = req_addr;
    assign dm_wdata     = req_wdata;
    assign dm_mem_write = accept && req_we;
    assign dm_mem_read  = accept && !req_we;
    assign dm_half      = accept && (size == 3'd2);
    assign dm_byte      = accept && (size == 3'd1);
    assign stall_o      = (state == S_WAIT);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept && !req_we) state_nxt = S_WAIT;
            S_WAIT:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    lsu_load_ext u_ext (
        .funct3 (pend.funct3),
        .raw    (dm_rdata),
        .ext    (ext_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            pend          <= '0;
            wb_valid_o    <= 1'b0;
            wb_rd_o       <= 5'd0;
            wb_data_o     <= 32'd0;
            fault_o       <= 1'b0;
            fault_store_o <= 1'b0;
            fault_addr_o  <= 32'd0;
        end else begin
            state      <= state_nxt;
            wb_valid_o <= (state == S_WAIT);
            fault_o    <= bad;
            if (accept && !req_we) begin
                pend.funct3 <= req_funct3;
                pend.rd     <= req_rd;
            end
            if (state == S_WAIT) begin
                wb_data_o <= ext_data;
                wb_rd_o   <= pend.rd;
            end
            if (bad) begin
                fault_addr_o  <= req_addr;
                fault_store_o <= req_we;
            end
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl with a behavioural Data_mem and byte-array reference model.
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic [4:0]  req_rd;
    logic        stall_o, wb_valid_o, fault_o, fault_store_o;
    logic [4:0]  wb_rd_o;
    logic [31:0] wb_data_o, fault_addr_o, dm_addr, dm_wdata;
    logic        dm_mem_write, dm_mem_read, dm_half, dm_byte;
    logic [31:0] dm_rdata = 32'd0;

    always #5 clk = ~clk;

    lsu_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_we(req_we), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
        .stall_o(stall_o), .wb_valid_o(wb_valid_o), .wb_rd_o(wb_rd_o),
        .wb_data_o(wb_data_o), .fault_o(fault_o), .fault_store_o(fault_store_o),
        .fault_addr_o(fault_addr_o), .dm_addr(dm_addr), .dm_mem_write(dm_mem_write),
        .dm_mem_read(dm_mem_read), .dm_half(dm_half), .dm_byte(dm_byte),
        .dm_wdata(dm_wdata), .dm_rdata(dm_rdata)
    );

    // Data_mem: byte addressed, little endian, registered zero-extended read.
    logic [7:0] dmem [256];
    always @(posedge clk) begin
        logic [7:0] i;
        i = dm_addr[7:0];
        if (dm_mem_write) begin
            dmem[i] <= dm_wdata[7:0];
            if (!dm_byte) dmem[8'(i + 1)] <= dm_wdata[15:8];
            if (!dm_byte && !dm_half) begin
                dmem[8'(i + 2)] <= dm_wdata[23:16];
                dmem[8'(i + 3)] <= dm_wdata[31:24];
            end
        end
        if (dm_mem_read) begin
            if (dm_byte)      dm_rdata <= {24'd0, dmem[i]};
            else if (dm_half) dm_rdata <= {16'd0, dmem[8'(i + 1)], dmem[i]};
            else dm_rdata <= {dmem[8'(i + 3)], dmem[8'(i + 2)], dmem[8'(i + 1)], dmem[i]};
        end
    end

    // Reference model state
    int unsigned ref_mem [256];
    typedef struct {
        bit          is_fault;
        logic [4:0]  rd;
        logic [31:0] val;
        bit          store;
        int          cyc;
    } exp_t;
    exp_t exp_q[$];

    int cyc = 0;
    int n_chk = 0;
    int n_pass = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic int unsigned ref_size(input logic [2:0] f3);
        int unsigned m = f3 % 4;
        return (m == 0) ? 1 : (m == 1) ? 2 : (m == 2) ? 4 : 0;
    endfunction

    function automatic bit ref_legal(input bit we, input logic [2:0] f3, input logic [31:0] a);
        int unsigned sz = ref_size(f3);
        bit f3_ok = we ? (f3 <= 2) : (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
        if (!f3_ok) return 0;
        if (longint'(a) + longint'(sz) > 256) return 0;
        return (a % sz) == 0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
        int unsigned i = a;
        int unsigned v = 0;
        case (f3)
            3'd0: begin v = ref_mem[i]; if (v >= 128) v = v + 32'hFFFFFF00; end
            3'd4: v = ref_mem[i];
            3'd1: begin v = ref_mem[i] + 256 * ref_mem[i+1]; if (v >= 32768) v = v + 32'hFFFF0000; end
            3'd5: v = ref_mem[i] + 256 * ref_mem[i+1];
            default: v = ref_mem[i] + 256 * ref_mem[i+1] + 65536 * ref_mem[i+2] + 16777216 * ref_mem[i+3];
        endcase
        return v;
    endfunction

    // Called at posedge+1; returns at posedge+1 once the LSU is ready for the next request.
    task automatic do_req(input bit we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [4:0] rd);
        bit ok;
        int unsigned sz;
        exp_t e;
        req_valid = 1'b1; req_we = we; req_funct3 = f3;
        req_addr = a; req_wdata = wd; req_rd = rd;
        #1;
        ok = ref_legal(we, f3, a);
        sz = ref_size(f3);
        chk("dm_strobes", {dm_mem_write, dm_mem_read, dm_half, dm_byte},
            {ok && we, ok && !we, ok && sz == 2, ok && sz == 1});
        chk("stall_idle", stall_o, 0);
        chk("dm_pass", {dm_addr, dm_wdata}, {a, wd});
        e.rd = rd; e.val = 0; e.store = we; e.is_fault = 0;
        if (!ok) begin
            e.is_fault = 1; e.val = a; e.cyc = cyc + 1;
            exp_q.push_back(e);
        end else if (we) begin
            for (int k = 0; k < int'(sz); k++) ref_mem[a + k] = (wd >> (8 * k)) & 255;
        end else begin
            e.val = ref_load(f3, a); e.cyc = cyc + 2;
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        if (ok && !we) begin
            chk("stall_wait", stall_o, 1);
            chk("wait_strobes", {dm_mem_write, dm_mem_read}, 0);
            @(posedge clk); #1;
        end
    endtask

    task automatic idle_cycle();
        req_valid = 1'b0; req_we = 1'($urandom); req_funct3 = 3'($urandom);
        req_addr = $urandom_range(0, 63); req_wdata = $urandom;
        #1;
        chk("idle_strobes", {dm_mem_write, dm_mem_read, dm_half, dm_byte, stall_o}, 0);
        @(posedge clk); #1;
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a response.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && (wb_valid_o || fault_o)) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_resp", {wb_valid_o, fault_o}, 0);
            end else begin
                e = exp_q.pop_front();
                chk("resp_kind", {wb_valid_o, fault_o}, {!e.is_fault, e.is_fault});
                chk("resp_cycle", cyc, e.cyc);
                if (e.is_fault) chk("fault_info", {fault_store_o, fault_addr_o}, {e.store, e.val});
                else chk("wb_info", {wb_rd_o, wb_data_o}, {e.rd, e.val});
            end
        end
    end

    initial begin
        for (int i = 0; i < 256; i++) begin dmem[i] = 8'd0; ref_mem[i] = 0; end
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
        req_addr = 32'd0; req_wdata = 32'd0; req_rd = 5'd0;
        #3;
        chk("reset_outs", {stall_o, wb_valid_o, wb_rd_o, wb_data_o, fault_o, fault_store_o},
            0);
        chk("reset_faddr", fault_addr_o, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // T1 store / load word
        do_req(1, 3'd2, 32'h10, 32'hDEADBEEF, 5'd0);
        do_req(0, 3'd2, 32'h10, 32'h0, 5'd1);
        // T2 extension
        do_req(1, 3'd0, 32'h20, 32'h00000080, 5'd0);
        do_req(0, 3'd0, 32'h20, 32'h0, 5'd2);
        do_req(0, 3'd4, 32'h20, 32'h0, 5'd3);
        do_req(1, 3'd1, 32'h22, 32'h12348001, 5'd0);
        do_req(0, 3'd1, 32'h22, 32'h0, 5'd4);
        do_req(0, 3'd5, 32'h22, 32'h0, 5'd5);
        // T3 faults: out of range, misaligned store, bad funct3, wrap-around
        do_req(0, 3'd2, 32'hFD, 32'h0, 5'd6);
        do_req(1, 3'd1, 32'h11, 32'hAAAA5555, 5'd0);
        do_req(0, 3'd2, 32'h10, 32'h0, 5'd7);
        do_req(0, 3'd3, 32'h10, 32'h0, 5'd8);
        do_req(1, 3'd4, 32'h10, 32'h0, 5'd0);
        do_req(0, 3'd0, 32'hFFFFFFFF, 32'h0, 5'd9);
        do_req(0, 3'd2, 32'hFC, 32'h0, 5'd10);
        // T4 back-to-back
        do_req(1, 3'd2, 32'h40, 32'h01020304, 5'd0);
        do_req(1, 3'd2, 32'h44, 32'hA0B0C0D0, 5'd0);
        do_req(0, 3'd2, 32'h40, 32'h0, 5'd11);
        do_req(0, 3'd2, 32'h44, 32'h0, 5'd12);
        idle_cycle();

        // T5 reset during WAIT
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h40; req_rd = 5'd13;
        @(posedge clk); #1;
        chk("t5_stall_wait", stall_o, 1);
        rst_n = 1'b0; req_valid = 1'b0;
        #1;
        chk("t5_stall_rst", stall_o, 0);
        chk("t5_outs_rst", {wb_valid_o, wb_rd_o, wb_data_o, fault_o}, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        repeat (3) idle_cycle();
        do_req(0, 3'd2, 32'h44, 32'h0, 5'd14);

        // Randomized traffic
        for (int n = 0; n < 300; n++) begin
            int unsigned r = $urandom_range(0, 9);
            logic [31:0] a;
            if (r == 0)      a = $urandom;
            else if (r <= 2) a = $urandom_range(240, 255);
            else             a = $urandom_range(0, 63);
            if ($urandom_range(0, 7) == 0) idle_cycle();
            do_req(1'($urandom), 3'($urandom), a, $urandom, 5'($urandom));
        end
        idle_cycle();

        for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(posedge clk);
        #1;
        chk("drain", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
